// File: rtl/hz_pkg.sv
// Shared definitions for the hazard control unit: forwarding mux
// encodings, the mul/div FSM state type and the zero-register index.
package hz_pkg;

    // Operand-mux selects driven to the ex stage (2'b11 is never used)
    localparam logic [1:0] FWD_RF  = 2'b00;  // value read from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // value from the wb stage
    localparam logic [1:0] FWD_MEM = 2'b10;  // value from the mem stage

    // Register 0 is hard-wired to zero and is never a real dependency
    localparam int REG_ZERO = 0;

    // Width of the mul/div down-counter; holds MULDIV_LAT-2 for LAT up to 15
    localparam int MD_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hz_fwd_sel.sv
// Forwarding priority mux for one ex-stage source operand. The mem stage
// holds the younger result, so it wins over wb when both match. A source
// of register 0 is never forwarded.
module hz_fwd_sel
    import hz_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_ex_i,
    input  logic [REG_AW-1:0] rd_mem_i,
    input  logic              reg_wr_mem_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              reg_wr_wb_i,
    output logic [1:0]        sel_o
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = reg_wr_mem_i && (rd_mem_i != ZERO) && (rd_mem_i == src_ex_i);
    assign wb_hit  = reg_wr_wb_i  && (rd_wb_i  != ZERO) && (rd_wb_i  == src_ex_i);

    // Pick the youngest matching producer, falling back to the register file
    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_MEM;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for the 5-stage pipeline: ex-stage operand
// forwarding, load-use stall/bubble, taken-branch flush of the issue
// register and a multi-cycle mul/div busy FSM that freezes the front end.
// Optional feature macro: HZ_PERF_CNT_EN adds saturating per-cause
// stall/flush cycle counters.
//
// Control outputs are level signals sampled by the pipeline registers on
// the next rising clk edge; there is no valid/ready handshake here.
// Priority, highest first: reset, mul/div BUSY, branch flush, load-use.
module hazard_ctrl_unit
    import hz_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_iss_hz_i,
    input  logic [REG_AW-1:0] rt_iss_hz_i,
    input  logic [REG_AW-1:0] rs_ex_hz_i,
    input  logic [REG_AW-1:0] rt_ex_hz_i,
    input  logic [REG_AW-1:0] rd_ex_hz_i,
    input  logic              mem_to_reg_ex_hz_i,
    input  logic [REG_AW-1:0] rd_mem_hz_i,
    input  logic              reg_wr_mem_hz_i,
    input  logic [REG_AW-1:0] rd_wb_hz_i,
    input  logic              reg_wr_wb_hz_i,
    input  logic              muldiv_start_ex_hz_i,
    input  logic              branch_taken_ex_hz_i,
    output logic              stall_fetch_hz_o,
    output logic              stall_iss_hz_o,
    output logic              stall_ex_hz_o,
    output logic              flush_iss_hz_o,
    output logic              flush_ex_hz_o,
    output logic [1:0]        fwd_p1_ex_hz_o,
    output logic [1:0]        fwd_p2_ex_hz_o,
    output logic              muldiv_busy_hz_o,
`ifdef HZ_PERF_CNT_EN
    output logic [CNT_W-1:0]  lu_stall_cnt_hz_o,
    output logic [CNT_W-1:0]  muldiv_stall_cnt_hz_o,
    output logic [CNT_W-1:0]  flush_cnt_hz_o,
`endif
    output hz_state_e         fsm_state_dbg_hz_o
);

    localparam logic [REG_AW-1:0]   ZERO    = REG_AW'(REG_ZERO);
    // Start cycle is not a stall cycle, so BUSY lasts MULDIV_LAT-1 cycles
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_LAT - 2);
    localparam logic [MD_CNT_W-1:0] MD_ONE  = MD_CNT_W'(1);

    hz_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    logic       lu_hit;
    logic       stall_fetch_c, stall_iss_c, stall_ex_c;
    logic       flush_iss_c, flush_ex_c, busy_c, lu_stall_c;
    logic [1:0] p1_sel, p2_sel;

    // Operand forwarding, one priority mux per ex-stage source
    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_p1 (
        .src_ex_i     (rs_ex_hz_i),
        .rd_mem_i     (rd_mem_hz_i),
        .reg_wr_mem_i (reg_wr_mem_hz_i),
        .rd_wb_i      (rd_wb_hz_i),
        .reg_wr_wb_i  (reg_wr_wb_hz_i),
        .sel_o        (p1_sel)
    );

    hz_fwd_sel #(.REG_AW(REG_AW)) u_fwd_p2 (
        .src_ex_i     (rt_ex_hz_i),
        .rd_mem_i     (rd_mem_hz_i),
        .reg_wr_mem_i (reg_wr_mem_hz_i),
        .rd_wb_i      (rd_wb_hz_i),
        .reg_wr_wb_i  (reg_wr_wb_hz_i),
        .sel_o        (p2_sel)
    );

    // A load in ex whose destination feeds the issue-stage instruction
    assign lu_hit = mem_to_reg_ex_hz_i && (rd_ex_hz_i != ZERO) &&
                    ((rd_ex_hz_i == rs_iss_hz_i) || (rd_ex_hz_i == rt_iss_hz_i));

    // Mul/div FSM state and down-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state plus stall/flush decisions; BUSY freezes everything and
    // masks branch, load-use and further starts
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_fetch_c = 1'b0;
        stall_iss_c   = 1'b0;
        stall_ex_c    = 1'b0;
        flush_iss_c   = 1'b0;
        flush_ex_c    = 1'b0;
        busy_c        = 1'b0;
        lu_stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (muldiv_start_ex_hz_i) begin
                    state_d = BUSY;
                    cnt_d   = MD_LOAD;
                end
                if (branch_taken_ex_hz_i) begin
                    flush_iss_c = 1'b1;
                end else if (lu_hit) begin
                    lu_stall_c    = 1'b1;
                    stall_fetch_c = 1'b1;
                    stall_iss_c   = 1'b1;
                    flush_ex_c    = 1'b1;
                end
            end
            BUSY: begin
                stall_fetch_c = 1'b1;
                stall_iss_c   = 1'b1;
                stall_ex_c    = 1'b1;
                busy_c        = 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - MD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are held at their idle values while reset is asserted
    assign stall_fetch_hz_o   = rst_n & stall_fetch_c;
    assign stall_iss_hz_o     = rst_n & stall_iss_c;
    assign stall_ex_hz_o      = rst_n & stall_ex_c;
    assign flush_iss_hz_o     = rst_n & flush_iss_c;
    assign flush_ex_hz_o      = rst_n & flush_ex_c;
    assign muldiv_busy_hz_o   = rst_n & busy_c;
    assign fwd_p1_ex_hz_o     = rst_n ? p1_sel : FWD_RF;
    assign fwd_p2_ex_hz_o     = rst_n ? p2_sel : FWD_RF;
    assign fsm_state_dbg_hz_o = state_q;

`ifdef HZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] lu_cnt_q, md_cnt_q, fl_cnt_q;

    // Saturating cycle counters, one per pipeline-control cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (lu_stall_c && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + CNT_ONE;
            if (busy_c     && (md_cnt_q != '1)) md_cnt_q <= md_cnt_q + CNT_ONE;
            if (flush_iss_c && (fl_cnt_q != '1)) fl_cnt_q <= fl_cnt_q + CNT_ONE;
        end
    end

    assign lu_stall_cnt_hz_o     = lu_cnt_q;
    assign muldiv_stall_cnt_hz_o = md_cnt_q;
    assign flush_cnt_hz_o        = fl_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Second-generation hazard unit for the 5-stage MIPS pipeline (fetch, issue/decode, ex, mem, wb). It adds the following to the existing forwarding-only behaviour:
- parametrised register-address width;
- zero-register suppression and two-source forwarding priority;
- load-use stall/bubble insertion;
- taken-branch flush;
- a multi-cycle mul/div busy FSM with down-counter.
It sits beside the pipeline registers and drives their stall/flush enables and the ex-stage operand muxes.

Parameters:
REG_AW, 5, register address width (32 GPRs)
MULDIV_LAT, 4, total ex-stage cycles of a mul/div op; legal range 2..15
CNT_W, 16, perf counter width (optional feature only)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
rs_iss_hz_i  in  REG_AW  rs of instruction in issue stage
rt_iss_hz_i  in  REG_AW  rt of instruction in issue stage
rs_ex_hz_i  in  REG_AW  rs of instruction in ex stage
rt_ex_hz_i  in  REG_AW  rt of instruction in ex stage
rd_ex_hz_i  in  REG_AW  destination of instruction in ex stage
mem_to_reg_ex_hz_i  in  1  ex-stage instruction is a load
rd_mem_hz_i  in  REG_AW  destination in mem stage
reg_wr_mem_hz_i  in  1  mem-stage instruction writes a register
rd_wb_hz_i  in  REG_AW  destination in wb stage
reg_wr_wb_hz_i  in  1  wb-stage instruction writes a register
muldiv_start_ex_hz_i  in  1  mul/div entering ex this cycle
branch_taken_ex_hz_i  in  1  branch/jump resolved taken in ex
stall_fetch_hz_o  out  1  hold PC and fetch register
stall_iss_hz_o  out  1  hold issue register
stall_ex_hz_o  out  1  hold ex register (mul/div busy)
flush_iss_hz_o  out  1  clear issue register to NOP
flush_ex_hz_o  out  1  insert bubble into ex register
fwd_p1_ex_hz_o  out  2  operand-1 mux select
fwd_p2_ex_hz_o  out  2  operand-2 mux select
muldiv_busy_hz_o  out  1  FSM in BUSY state

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE and the counter goes to 0.
  - All stall/flush/busy outputs are 0 and fwd selects are 2'b00, forced regardless of the other inputs while reset is asserted.
- Forwarding (combinational, zero latency). Shown for p1; p2 is identical using rt_ex_hz_i.
  - Sel 2'b10 if reg_wr_mem && rd_mem != 0 && rd_mem == rs_ex.
  - Else sel 2'b01 if reg_wr_wb && rd_wb != 0 && rd_wb == rs_ex.
  - Else sel 2'b00 (register file).
  - The mem stage wins when both mem and wb match. 2'b11 is never driven.
- Load-use (combinational):
  - lu = mem_to_reg_ex && rd_ex != 0 && (rd_ex == rs_iss || rd_ex == rt_iss).
  - lu asserts stall_fetch, stall_iss and flush_ex for exactly one cycle; the load advances, so lu self-clears.
- Branch: branch_taken_ex asserts flush_iss for that cycle and overrides lu (no stall, no ex flush from lu in that cycle).
- Mul/div FSM, states IDLE and BUSY:
  - IDLE -> BUSY when muldiv_start_ex=1; cnt <= MULDIV_LAT-2.
  - BUSY: cnt decrements each cycle. BUSY -> IDLE when cnt==0.
  - Total stall equals MULDIV_LAT-1 cycles after the start cycle.
  - In BUSY:
    - stall_fetch, stall_iss, stall_ex and muldiv_busy are 1.
    - lu and branch are ignored: the ex instruction is frozen and no flush is emitted.
    - muldiv_start_ex is ignored.
- Start cycle (IDLE with muldiv_start_ex=1): no stall yet. A coincident lu is honoured normally.
- Priority, highest first: reset, BUSY, branch flush, load-use.
- Reset mid-BUSY aborts the op; outputs return to 0 immediately (async).

Optional Feature:
HZ_PERF_CNT_EN.
- Defined: adds outputs lu_stall_cnt_hz_o, muldiv_stall_cnt_hz_o and flush_cnt_hz_o, each CNT_W wide.
  - Each counts cycles in which its cause drives the pipeline (lu stall, BUSY, flush_iss).
  - Each saturates at all-ones and is cleared by rst_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
Shared package hz_pkg holds:
- the FWD_RF=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 constants;
- the FSM state typedef (IDLE, BUSY);
- the REG_ZERO constant.
One natural sub-module is hz_fwd_sel: the combinational priority mux for one operand, instantiated twice.

Test Plan:
1. reg_wr_mem=1, rd_mem=7, reg_wr_wb=1, rd_wb=7, rs_ex=7, rt_ex=3 -> fwd_p1=2'b10, fwd_p2=2'b00.
2. reg_wr_mem=1, rd_mem=0, rs_ex=0 -> fwd_p1=2'b00 (zero register never forwarded).
3. mem_to_reg_ex=1, rd_ex=5, rt_iss=5 -> stall_fetch=stall_iss=flush_ex=1 for one cycle; next cycle (rd_ex now other) all 0.
4. Same as 3 plus branch_taken_ex=1 -> flush_iss=1, stall_fetch=stall_iss=flush_ex=0.
5. MULDIV_LAT=4, muldiv_start_ex pulse at cycle 0 -> stall_ex/busy=1 in cycles 1..3, 0 at cycle 4; a branch_taken pulse in cycle 2 produces no flush_iss.
6. Assert rst_n=0 in cycle 2 of BUSY -> busy and stalls drop asynchronously. After release, busy=0 and a new start stalls a full MULDIV_LAT-1 cycles.
